// File: rtl/spi_rx_lane.sv
// SPI slave receive lane (mode 0, MSB first).
// The SPI pins are resynchronised into sysclk and sampled there. Each
// received word passes through a one-word hold slot, so that the final word
// of a CS_n frame can be tagged with last, and then into a first-word-fall-
// through output FIFO. MISO tells the master whether the FIFO has room.
//
// Handshake: a beat transfers on a sysclk rising edge when m_tvalid and
// m_tready are both 1. m_tvalid stays 1, with m_tdata/m_tlast stable, until
// that edge. m_tvalid never depends on m_tready.
module spi_rx_lane #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              CS_n,
  output logic              MISO,
  output logic [WORD_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  input  logic              err_clr,
  output logic              ovf,
  output logic              frame_err,
  output logic              dbg_state_o
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  // Synchronizer stages
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  // Capture state
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-2:0]  shift_q;
  logic [WORD_W-1:0]  hold_q;
  logic               hold_vld_q;
  logic               push_q;
  logic [WORD_W-1:0]  push_data_q;
  logic               push_last_q;
  logic               frame_err_q;

  // FIFO state
  logic [WORD_W-1:0]  mem_data [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q;
  logic               miso_q;

  // Derived capture signals
  logic               sclk_rise;
  logic               cs_fall;
  logic               word_done;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   cnt_adv;
  logic [WORD_W-1:0]  word_nxt;

  // Derived FIFO signals
  logic               pop;
  logic               push_ok;
  logic               ovf_set;

  // Two-stage synchronizers on all pins; SCLK and CS_n get a third stage for edge detection
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      cs_s1_q   <= CS_n;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;
  assign word_done = sclk_rise && (cnt_q == LAST_BIT);
  assign cnt_inc   = word_done ? '0 : cnt_q + CNT_W'(1);
  assign cnt_adv   = sclk_rise ? cnt_inc : cnt_q;
  assign word_nxt  = {shift_q, mosi_s2_q};

  // Capture FSM: shifts bits, manages the hold slot and issues registered FIFO pushes
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_last_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr) frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A word left in the slot here is the one that completed on the
          // closing edge while an older word still occupied the slot.
          if (hold_vld_q) begin
            push_q      <= 1'b1;
            push_data_q <= hold_q;
            push_last_q <= 1'b1;
            hold_vld_q  <= 1'b0;
          end
          if (cs_fall) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            shift_q <= word_nxt[WORD_W-2:0];
            cnt_q   <= cnt_inc;
          end
          if (cs_s2_q) begin
            // Frame closes; a word completing on this same edge is the last one
            state_q <= ST_IDLE;
            if (word_done) begin
              if (hold_vld_q) begin
                push_q      <= 1'b1;
                push_data_q <= hold_q;
                push_last_q <= 1'b0;
                hold_q      <= word_nxt;
              end else begin
                push_q      <= 1'b1;
                push_data_q <= word_nxt;
                push_last_q <= 1'b1;
              end
            end else begin
              if (hold_vld_q) begin
                push_q      <= 1'b1;
                push_data_q <= hold_q;
                push_last_q <= 1'b1;
                hold_vld_q  <= 1'b0;
              end
              if (cnt_adv != '0) frame_err_q <= 1'b1;
            end
          end else if (word_done) begin
            if (hold_vld_q) begin
              push_q      <= 1'b1;
              push_data_q <= hold_q;
              push_last_q <= 1'b0;
            end
            hold_q     <= word_nxt;
            hold_vld_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIFO control: a push into a full FIFO is accepted only when a pop frees a slot
  always_comb begin
    pop      = (count_q != '0) && m_tready;
    push_ok  = push_q && ((count_q != DEPTH_C) || pop);
    ovf_set  = push_q && (count_q == DEPTH_C) && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
  end

  // FIFO pointers, occupancy, overflow flag and registered MISO status
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      miso_q   <= (DEPTH_C - count_d) >= CW'(2);
      if (ovf_set) ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge sysclk) begin
    if (push_ok) begin
      mem_data[wr_ptr_q] <= push_data_q;
      mem_last[wr_ptr_q] <= push_last_q;
    end
  end

  assign m_tvalid    = (count_q != '0);
  assign m_tdata     = m_tvalid ? mem_data[rd_ptr_q] : '0;
  assign m_tlast     = m_tvalid & mem_last[rd_ptr_q];
  assign ovf         = ovf_q;
  assign frame_err   = frame_err_q;
  assign MISO        = miso_q;
  assign dbg_state_o = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_rx_lane.sv
// Directed bench for spi_rx_lane: SPI master driver tasks, a beat monitor
// feeding got_q, an expected-beat queue and a single check task.
module tb_spi_rx_lane;

  localparam int W    = 32;
  localparam int HALF = 40;

  logic         sysclk   = 1'b0;
  logic         rst      = 1'b1;
  logic         SCLK     = 1'b0;
  logic         MOSI     = 1'b0;
  logic         CS_n     = 1'b1;
  logic         m_tready = 1'b0;
  logic         err_clr  = 1'b0;
  logic         MISO;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         ovf;
  logic         frame_err;
  logic         dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0] exp_q[$];
  logic [W:0] got_q[$];

  spi_rx_lane #(.WORD_W(W), .FIFO_DEPTH(8)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .CS_n        (CS_n),
    .MISO        (MISO),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .err_clr     (err_clr),
    .ovf         (ovf),
    .frame_err   (frame_err),
    .dbg_state_o (dbg_state)
  );

  // Clock / watchdog
  always #5 sysclk = ~sysclk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  // Beat monitor: samples away from the active edge
  always @(negedge sysclk) begin
    if (!rst && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    MOSI = b;
    #HALF;
    SCLK = 1'b1;
    #HALF;
    SCLK = 1'b0;
  endtask

  task automatic spi_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) spi_bit(w[i]);
  endtask

  // Last SCLK rise and CS_n rise at the same instant
  task automatic spi_word_close(input logic [W-1:0] w);
    for (int i = W - 1; i >= 1; i--) spi_bit(w[i]);
    MOSI = w[0];
    #HALF;
    SCLK = 1'b1;
    CS_n = 1'b1;
    #HALF;
    SCLK = 1'b0;
    #(HALF * 2);
  endtask

  task automatic cs_open();
    CS_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_close();
    #HALF;
    CS_n = 1'b1;
    #(HALF * 2);
  endtask

  task automatic push_exp(input logic last, input logic [W-1:0] data);
    exp_q.push_back({last, data});
  endtask

  // Scoreboard: wait (bounded) for the expected beats, then compare in order
  task automatic expect_beats(input string tag);
    int budget;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 500) begin
      @(posedge sysclk);
      budget++;
    end
    tick(20);
    chk({tag, " beat count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, " beat"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    int lat;

    // Reset values
    rst = 1'b1;
    tick(3);
    chk("rst m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst m_tdata", 64'(m_tdata), 64'(0));
    chk("rst m_tlast", 64'(m_tlast), 64'(0));
    chk("rst MISO", 64'(MISO), 64'(0));
    chk("rst ovf", 64'(ovf), 64'(0));
    chk("rst frame_err", 64'(frame_err), 64'(0));
    chk("rst state", 64'(dbg_state), 64'(0));
    rst = 1'b0;
    tick(3);
    chk("idle MISO", 64'(MISO), 64'(1));

    // Three-word frame
    m_tready = 1'b1;
    cs_open();
    spi_word(32'hA5A5_0001);
    spi_word(32'h0000_0002);
    spi_word(32'hFFFF_FFFF);
    cs_close();
    push_exp(1'b0, 32'hA5A5_0001);
    push_exp(1'b0, 32'h0000_0002);
    push_exp(1'b1, 32'hFFFF_FFFF);
    expect_beats("three_word");
    chk("three_word ovf", 64'(ovf), 64'(0));
    chk("three_word frame_err", 64'(frame_err), 64'(0));

    // Close-to-valid latency from raw CS_n rise
    m_tready = 1'b0;
    cs_open();
    spi_word(32'h5A5A_C3C3);
    #HALF;
    @(posedge sysclk);
    #1;
    CS_n = 1'b1;
    lat = 99;
    for (int k = 1; k <= 6; k++) begin
      @(posedge sysclk);
      #1;
      if (m_tvalid && lat == 99) lat = k;
    end
    chk("latency within 5", 64'(lat <= 5), 64'(1));
    chk("latency m_tdata", 64'(m_tdata), 64'(32'h5A5A_C3C3));
    chk("latency m_tlast", 64'(m_tlast), 64'(1));
    m_tready = 1'b1;
    push_exp(1'b1, 32'h5A5A_C3C3);
    expect_beats("latency");

    // Partial word at frame end, then sticky frame_err
    cs_open();
    spi_word(32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    cs_close();
    push_exp(1'b1, 32'h0BAD_F00D);
    expect_beats("partial");
    chk("partial frame_err set", 64'(frame_err), 64'(1));
    cs_open();
    spi_word(32'h1111_1111);
    cs_close();
    push_exp(1'b1, 32'h1111_1111);
    expect_beats("clean_after_partial");
    chk("frame_err sticky", 64'(frame_err), 64'(1));
    pulse_err_clr();
    chk("frame_err cleared", 64'(frame_err), 64'(0));

    // Overflow: ten words with no downstream accept
    m_tready = 1'b0;
    cs_open();
    for (int k = 1; k <= 10; k++) begin
      spi_word(32'h1000_0000 + 32'(k));
      if (k == 7) begin
        #100;
        chk("MISO with 6 stored", 64'(MISO), 64'(1));
      end
      if (k == 8) begin
        #100;
        chk("MISO with 7 stored", 64'(MISO), 64'(0));
      end
    end
    cs_close();
    tick(10);
    chk("overflow ovf", 64'(ovf), 64'(1));
    chk("overflow MISO", 64'(MISO), 64'(0));
    chk("overflow frame_err", 64'(frame_err), 64'(0));
    m_tready = 1'b1;
    for (int k = 1; k <= 8; k++) push_exp(1'b0, 32'h1000_0000 + 32'(k));
    expect_beats("overflow drain");
    chk("ovf sticky", 64'(ovf), 64'(1));
    chk("MISO after drain", 64'(MISO), 64'(1));
    pulse_err_clr();
    chk("ovf cleared", 64'(ovf), 64'(0));

    // Full FIFO with simultaneous push and pop
    m_tready = 1'b0;
    cs_open();
    for (int k = 1; k <= 9; k++) spi_word(32'h2000_0000 + 32'(k));
    tick(10);
    chk("full ovf before", 64'(ovf), 64'(0));
    chk("full MISO", 64'(MISO), 64'(0));
    @(posedge sysclk);
    #1;
    CS_n = 1'b1;
    tick(3);
    m_tready = 1'b1;
    tick(1);
    m_tready = 1'b0;
    chk("full push+pop ovf", 64'(ovf), 64'(0));
    chk("full push+pop MISO", 64'(MISO), 64'(0));
    tick(5);
    m_tready = 1'b1;
    for (int k = 1; k <= 8; k++) push_exp(1'b0, 32'h2000_0000 + 32'(k));
    push_exp(1'b1, 32'h2000_0009);
    expect_beats("full push+pop");
    chk("full push+pop ovf end", 64'(ovf), 64'(0));

    // Word completion coinciding with CS_n rise
    cs_open();
    spi_word(32'h0123_4567);
    spi_word_close(32'h89AB_CDEF);
    push_exp(1'b0, 32'h0123_4567);
    push_exp(1'b1, 32'h89AB_CDEF);
    expect_beats("coincide held");
    chk("coincide held frame_err", 64'(frame_err), 64'(0));
    cs_open();
    spi_word_close(32'hCAFE_BABE);
    push_exp(1'b1, 32'hCAFE_BABE);
    expect_beats("coincide single");
    chk("coincide single frame_err", 64'(frame_err), 64'(0));

    // Reset in the middle of a frame
    m_tready = 1'b0;
    cs_open();
    spi_word(32'hDEAD_BEEF);
    cs_close();
    tick(5);
    chk("pre-reset m_tvalid", 64'(m_tvalid), 64'(1));
    cs_open();
    for (int i = 0; i < 17; i++) spi_bit(i[0]);
    rst = 1'b1;
    CS_n = 1'b1;
    #1;
    chk("midrst m_tvalid", 64'(m_tvalid), 64'(0));
    chk("midrst m_tdata", 64'(m_tdata), 64'(0));
    chk("midrst m_tlast", 64'(m_tlast), 64'(0));
    chk("midrst MISO", 64'(MISO), 64'(0));
    chk("midrst ovf", 64'(ovf), 64'(0));
    chk("midrst frame_err", 64'(frame_err), 64'(0));
    tick(2);
    rst = 1'b0;
    tick(3);
    m_tready = 1'b1;
    expect_beats("after reset");
    cs_open();
    spi_word(32'h1234_5678);
    cs_close();
    push_exp(1'b1, 32'h1234_5678);
    expect_beats("post reset frame");
    chk("post reset frame_err", 64'(frame_err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
